gf180mcu_fd_sc_mcu9t5v0__syncfilt: RTL and testbench
====================================================

Name: gf180mcu_fd_sc_mcu9t5v0__syncfilt

Overview:
- Input-conditioning macro that consumes a raw, asynchronous single-bit level, such as the ZN output of an inverter stage driven from a pad.
- Function: N-flop synchronizer, then a counter-based glitch filter, then edge detection.
- Outputs: a clean filtered level, its complement, and single-cycle rise/fall strobes for downstream control logic.
- Serves as the library's behavioural reference for the debounced-input macro.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- FILT, 4, consecutive synchronized samples that must disagree with Z before Z changes; legal range 1..(2**CNT_W - 1).
- CNT_W, 4, width of the filter counter.
- RST_VAL, 1'b0, value loaded into the synchronizer flops and Z on reset.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- I    input  1  raw asynchronous level; no timing relation to CLK.
- EN   input  1  filter enable; synchronous to CLK.
- Z    output 1  filtered level, registered.
- ZN   output 1  ~Z, combinational from the Z register.
- RISE output 1  one-cycle pulse, high in the cycle after Z goes 0->1.
- FALL output 1  one-cycle pulse, high in the cycle after Z goes 1->0.

Behaviour:
- Reset: RST high immediately forces the following, independent of CLK:
  - all synchronizer flops = RST_VAL; Z = RST_VAL; ZN = ~RST_VAL;
  - RISE = FALL = 0; counter = 0; FSM = STABLE.
- Reset mid-qualification discards the pending transition. Release of RST takes effect at the first CLK edge after deassertion.
- Synchronizer: shift register clocked every cycle, including when EN=0. S = last stage output.
- FSM states:
  - STABLE: if EN and S!=Z, then if FILT==1 toggle Z (stay STABLE), else go to QUAL with cnt=1.
  - QUAL:
    - S==Z: back to STABLE, cnt=0 (glitch rejected, no output activity).
    - S!=Z and cnt==FILT-1: toggle Z, go to STABLE, cnt=0.
    - otherwise: cnt=cnt+1.
- Latency: count the first CLK edge that samples I at its new value as edge 1. Z changes on edge SYNC_STAGES+FILT (defaults: edge 6).
- Pulse width acceptance: an I pulse held for FILT-1 sampling edges never reaches Z; a pulse held for FILT edges does.
- EN=0:
  - Z frozen; FSM forced to STABLE; cnt=0 on the next edge; no RISE/FALL.
  - Re-enabling restarts qualification from zero.
- RISE/FALL: registered as Z & ~Z_prev and ~Z & Z_prev. Each is high for exactly one cycle, in the cycle following the Z update. They are never high simultaneously.
- Counter: never exceeds FILT-1, so no wrap. CNT_W must satisfy FILT < 2**CNT_W.
- Elaboration: an illegal parameter combination triggers an $error / fatal at elaboration.
- Timing model:
  - Under `FUNCTIONAL`: zero-delay.
  - Otherwise: a specify block with CLK->Z, CLK->ZN, CLK->RISE, CLK->FALL and RST->Z arcs, each (1.0,1.0). Also $setuphold on EN vs CLK and $recrem on RST vs CLK.

Decomposition:
- Shared package gf180mcu_fd_sc_mcu9t5v0__syncfilt_pkg holds:
  - FSM state typedef (STABLE, QUAL);
  - default parameter constants;
  - a function that checks FILT/CNT_W legality.
- One sub-module, gf180mcu_fd_sc_mcu9t5v0__syncfilt_func, holds all functional RTL (synchronizer, FSM, edge detect).
- The top wrapper instantiates it and carries only the specify block, matching the library's _func/behavioural split.

Test Plan:
- Reset: RST=1 asynchronously mid-cycle with RST_VAL=0 -> Z=0, ZN=1, RISE=FALL=0 before the next CLK edge. Repeat with RST_VAL=1 -> Z=1, ZN=0.
- Latency: defaults, EN=1, I 0->1 before edge 1 -> Z=1 after edge 6, RISE=1 for exactly the cycle after edge 6, FALL stays 0. I 1->0 -> Z=0 after 6 edges, FALL=1 for one cycle.
- Glitch rejection: defaults, I high for 3 sampling edges then low -> Z, RISE and FALL never change. I high for 4 edges -> Z rises at edge 6 and falls 6 edges after I drops.
- EN gating: I rises, EN dropped at edge 4 and restored at edge 8 while I stays high -> Z stays 0 through edge 8 and rises at edge 12 (qualification restarted from zero).
- Reset mid-operation and FILT=1: RST pulsed at edge 4 of a qualifying rise -> Z stays 0 and the rise completes 6 edges after release. Separately, with FILT=1 and SYNC_STAGES=2, Z follows I at edge 3.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__syncfilt_pkg.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__syncfilt_pkg.sv - shared types, defaults and parameter check for syncfilt
package gf180mcu_fd_sc_mcu9t5v0__syncfilt_pkg;

   typedef enum logic {
      STABLE = 1'b0,
      QUAL   = 1'b1
   } state_t;

   localparam int   DEF_SYNC_STAGES = 2;
   localparam int   DEF_FILT        = 4;
   localparam int   DEF_CNT_W       = 4;
   localparam logic DEF_RST_VAL     = 1'b0;

   // Counter holds at most FILT-1, so FILT must fit strictly below 2**CNT_W.
   function automatic bit params_ok(input int sync_stages, input int filt, input int cnt_w);
      return (sync_stages >= 2) && (sync_stages <= 4) &&
             (cnt_w >= 1) && (cnt_w <= 16) &&
             (filt >= 1) && (filt < (1 << cnt_w));
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__syncfilt_if.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__syncfilt_if.sv - raw input and filtered output bundle
interface gf180mcu_fd_sc_mcu9t5v0__syncfilt_if;
   logic I;
   logic EN;
   logic Z;
   logic ZN;
   logic RISE;
   logic FALL;

   modport master (output I, EN, input Z, ZN, RISE, FALL);
   modport slave  (input I, EN, output Z, ZN, RISE, FALL);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__syncfilt_func.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__syncfilt_func.sv - synchronizer, glitch-filter FSM and edge strobes
module gf180mcu_fd_sc_mcu9t5v0__syncfilt_func
   import gf180mcu_fd_sc_mcu9t5v0__syncfilt_pkg::*;
#(
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   FILT        = DEF_FILT,
   parameter int   CNT_W       = DEF_CNT_W,
   parameter logic RST_VAL     = DEF_RST_VAL
) (
   input  logic CLK,
   input  logic RST,
   gf180mcu_fd_sc_mcu9t5v0__syncfilt_if.slave bus
);

   if (!params_ok(SYNC_STAGES, FILT, CNT_W)) begin : g_param_err
      $error("syncfilt: illegal SYNC_STAGES/FILT/CNT_W combination");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   state_t                 r_state;
   logic                   r_z;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_s;
   logic                   w_toggle;
   logic                   w_z_next;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_sync <= {SYNC_STAGES{RST_VAL}};
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.I};
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_toggle = 1'b0;
      if (bus.EN && (w_s != r_z)) begin
         if (r_state == STABLE) w_toggle = (FILT == 1);
         else                   w_toggle = (r_cnt == CNT_W'(FILT - 1));
      end
   end

   assign w_z_next = r_z ^ w_toggle;

   // Strobes are computed from the next Z so they line up with the Z update cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= STABLE;
         r_cnt   <= '0;
         r_z     <= RST_VAL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_z    <= w_z_next;
         r_rise <= w_z_next & ~r_z;
         r_fall <= ~w_z_next & r_z;
         if (!bus.EN) begin
            r_state <= STABLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               STABLE: begin
                  if ((w_s != r_z) && (FILT != 1)) begin
                     r_state <= QUAL;
                     r_cnt   <= CNT_W'(1);
                  end
               end
               QUAL: begin
                  if ((w_s == r_z) || w_toggle) begin
                     r_state <= STABLE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  r_state <= STABLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.Z    = r_z;
   assign bus.ZN   = ~r_z;
   assign bus.RISE = r_rise;
   assign bus.FALL = r_fall;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__syncfilt.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__syncfilt.sv - debounced-input macro wrapper with timing arcs
module gf180mcu_fd_sc_mcu9t5v0__syncfilt
   import gf180mcu_fd_sc_mcu9t5v0__syncfilt_pkg::*;
#(
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   FILT        = DEF_FILT,
   parameter int   CNT_W       = DEF_CNT_W,
   parameter logic RST_VAL     = DEF_RST_VAL
) (
   input  logic CLK,
   input  logic RST,
   input  logic I,
   input  logic EN,
   output logic Z,
   output logic ZN,
   output logic RISE,
   output logic FALL
);

   gf180mcu_fd_sc_mcu9t5v0__syncfilt_if w_bus ();

   assign w_bus.I  = I;
   assign w_bus.EN = EN;
   assign Z        = w_bus.Z;
   assign ZN       = w_bus.ZN;
   assign RISE     = w_bus.RISE;
   assign FALL     = w_bus.FALL;

   gf180mcu_fd_sc_mcu9t5v0__syncfilt_func #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT        (FILT),
      .CNT_W       (CNT_W),
      .RST_VAL     (RST_VAL)
   ) u_func (
      .CLK (CLK),
      .RST (RST),
      .bus (w_bus)
   );

`ifndef FUNCTIONAL
   specify
      (CLK => Z)    = (1.0, 1.0);
      (CLK => ZN)   = (1.0, 1.0);
      (CLK => RISE) = (1.0, 1.0);
      (CLK => FALL) = (1.0, 1.0);
      (RST => Z)    = (1.0, 1.0);
      $setuphold(posedge CLK, EN, 0.0, 0.0);
      $recrem(negedge RST, posedge CLK, 0.0, 0.0);
   endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__syncfilt.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__syncfilt.sv - self-checking bench for the syncfilt macro
module tb_gf180mcu_fd_sc_mcu9t5v0__syncfilt;

   typedef struct {
      logic i;
      logic en;
      logic z;
      logic rise;
      logic fall;
   } vec_t;

   typedef struct packed {
      logic z;
      logic rise;
      logic fall;
   } exp_t;

   logic CLK;
   logic RST;
   int   n_checks;
   int   n_errors;
   vec_t vecs[$];
   exp_t sb_q[$];

   gf180mcu_fd_sc_mcu9t5v0__syncfilt_if bus0 ();
   gf180mcu_fd_sc_mcu9t5v0__syncfilt_if bus1 ();
   gf180mcu_fd_sc_mcu9t5v0__syncfilt_if bus2 ();

   gf180mcu_fd_sc_mcu9t5v0__syncfilt dut0 (
      .CLK (CLK), .RST (RST), .I (bus0.I), .EN (bus0.EN),
      .Z (bus0.Z), .ZN (bus0.ZN), .RISE (bus0.RISE), .FALL (bus0.FALL)
   );

   gf180mcu_fd_sc_mcu9t5v0__syncfilt #(.RST_VAL(1'b1)) dut1 (
      .CLK (CLK), .RST (RST), .I (bus1.I), .EN (bus1.EN),
      .Z (bus1.Z), .ZN (bus1.ZN), .RISE (bus1.RISE), .FALL (bus1.FALL)
   );

   gf180mcu_fd_sc_mcu9t5v0__syncfilt #(.FILT(1)) dut2 (
      .CLK (CLK), .RST (RST), .I (bus2.I), .EN (bus2.EN),
      .Z (bus2.Z), .ZN (bus2.ZN), .RISE (bus2.RISE), .FALL (bus2.FALL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic act, input logic exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic add(input int n, input logic i, input logic en,
                      input logic z, input logic r, input logic f);
      vec_t v;
      v.i = i; v.en = en; v.z = z; v.rise = r; v.fall = f;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   // Drives dut0 for one edge, queues the expectation, and checks after the edge.
   task automatic step(input string tag, input logic i, input logic en,
                       input logic z, input logic r, input logic f);
      exp_t e;
      bus0.I  = i;
      bus0.EN = en;
      sb_q.push_back('{z: z, rise: r, fall: f});
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      chk({tag, " Z"},    bus0.Z,    e.z);
      chk({tag, " ZN"},   bus0.ZN,   ~e.z);
      chk({tag, " RISE"}, bus0.RISE, e.rise);
      chk({tag, " FALL"}, bus0.FALL, e.fall);
      @(negedge CLK);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      // latency rise / fall
      add(5, 1, 1, 0, 0, 0); add(1, 1, 1, 1, 1, 0); add(2, 1, 1, 1, 0, 0);
      add(5, 0, 1, 1, 0, 0); add(1, 0, 1, 0, 0, 1); add(2, 0, 1, 0, 0, 0);
      // 3-edge glitch rejected
      add(3, 1, 1, 0, 0, 0); add(6, 0, 1, 0, 0, 0);
      // 4-edge pulse accepted, falls 6 edges after I drops
      add(4, 1, 1, 0, 0, 0); add(1, 0, 1, 0, 0, 0); add(1, 0, 1, 1, 1, 0);
      add(3, 0, 1, 1, 0, 0); add(1, 0, 1, 0, 0, 1); add(1, 0, 1, 0, 0, 0);
      // EN low over edges 4..8 restarts qualification
      add(3, 1, 1, 0, 0, 0); add(5, 1, 0, 0, 0, 0); add(3, 1, 1, 0, 0, 0);
      add(1, 1, 1, 1, 1, 0); add(1, 1, 1, 1, 0, 0);
      add(5, 0, 1, 1, 0, 0); add(1, 0, 1, 0, 0, 1); add(1, 0, 1, 0, 0, 0);

      RST = 1'b1;
      bus0.I = 1'b0; bus0.EN = 1'b1;
      bus1.I = 1'b1; bus1.EN = 1'b1;
      bus2.I = 1'b0; bus2.EN = 1'b1;
      #3;
      chk("rst0 Z", bus0.Z, 1'b0);     chk("rst0 ZN", bus0.ZN, 1'b1);
      chk("rst0 RISE", bus0.RISE, 1'b0); chk("rst0 FALL", bus0.FALL, 1'b0);
      chk("rst1 Z", bus1.Z, 1'b1);     chk("rst1 ZN", bus1.ZN, 1'b0);
      chk("rst1 RISE", bus1.RISE, 1'b0); chk("rst1 FALL", bus1.FALL, 1'b0);
      @(negedge CLK);
      RST = 1'b0;

      for (int n = 0; n < vecs.size(); n++)
         step($sformatf("vec%0d", n), vecs[n].i, vecs[n].en, vecs[n].z, vecs[n].rise, vecs[n].fall);

      // async reset while RISE (dut0) and FALL (dut1) are active
      bus1.I = 1'b0;
      for (int k = 1; k <= 5; k++) step($sformatf("arst e%0d", k), 1, 1, 0, 0, 0);
      step("arst e6", 1, 1, 1, 1, 0);
      chk("arst1 pre Z", bus1.Z, 1'b0);
      chk("arst1 pre FALL", bus1.FALL, 1'b1);
      RST = 1'b1;
      #1;
      chk("arst0 Z", bus0.Z, 1'b0);       chk("arst0 ZN", bus0.ZN, 1'b1);
      chk("arst0 RISE", bus0.RISE, 1'b0); chk("arst0 FALL", bus0.FALL, 1'b0);
      chk("arst1 Z", bus1.Z, 1'b1);       chk("arst1 ZN", bus1.ZN, 1'b0);
      chk("arst1 FALL", bus1.FALL, 1'b0);
      bus0.I = 1'b0;
      bus1.I = 1'b1;
      @(posedge CLK);
      #1;
      chk("arst0 held Z", bus0.Z, 1'b0);
      chk("arst0 held RISE", bus0.RISE, 1'b0);
      @(negedge CLK);
      RST = 1'b0;

      // reset mid-qualification discards the pending rise
      for (int k = 1; k <= 3; k++) step($sformatf("mq e%0d", k), 1, 1, 0, 0, 0);
      RST = 1'b1;
      #1;
      chk("mq rst Z", bus0.Z, 1'b0);
      @(posedge CLK);
      #1;
      chk("mq edge4 Z", bus0.Z, 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      for (int k = 1; k <= 5; k++) step($sformatf("mq post e%0d", k), 1, 1, 0, 0, 0);
      step("mq post e6", 1, 1, 1, 1, 0);
      step("mq post e7", 1, 1, 1, 0, 0);

      // FILT=1: Z follows I at edge 3
      for (int e = 1; e <= 8; e++) begin
         bus2.I = (e <= 4);
         @(posedge CLK);
         #1;
         chk($sformatf("f1 e%0d Z", e),    bus2.Z,    (e >= 3) && (e < 7));
         chk($sformatf("f1 e%0d ZN", e),   bus2.ZN,   !((e >= 3) && (e < 7)));
         chk($sformatf("f1 e%0d RISE", e), bus2.RISE, e == 3);
         chk($sformatf("f1 e%0d FALL", e), bus2.FALL, e == 7);
         @(negedge CLK);
      end

      chk("dut1 idle Z", bus1.Z, 1'b1);
      chk("scoreboard drained", sb_q.size() == 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
